// File: rtl/axi_lsu_router_if.sv
// axi_lsu_router bus types and port bundle.
// Payload structs for the LSU AXI port plus the interface that groups the
// master-side and slave-side buses of the router.

package axi_lsu_router_pkg;

  localparam int unsigned AXI_ID_W   = 4;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

  // Master-to-slave direction: AW, W, AR requests and B/R readies.
  typedef struct packed {
    logic [AXI_ID_W-1:0]   awid;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [AXI_LEN_W-1:0]  awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  bready;
    logic [AXI_ID_W-1:0]   arid;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [AXI_LEN_W-1:0]  arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  rready;
  } s_axi_mosi_t;

  // Slave-to-master direction: request readies and B/R responses.
  typedef struct packed {
    logic                  awready;
    logic                  wready;
    logic [AXI_ID_W-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  arready;
    logic [AXI_ID_W-1:0]   rid;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
  } s_axi_miso_t;

endpackage

interface axi_lsu_router_if;
  import axi_lsu_router_pkg::*;

  s_axi_mosi_t       mst_axi_mosi_i;
  s_axi_miso_t       mst_axi_miso_o;
  s_axi_mosi_t [1:0] slv_axi_mosi_o;
  s_axi_miso_t [1:0] slv_axi_miso_i;

  // Router side of the bundle.
  modport slave (
    input  mst_axi_mosi_i,
    output mst_axi_miso_o,
    output slv_axi_mosi_o,
    input  slv_axi_miso_i
  );

  // LSU master and downstream slaves side of the bundle.
  modport master (
    output mst_axi_mosi_i,
    input  mst_axi_miso_o,
    input  slv_axi_mosi_o,
    output slv_axi_miso_i
  );

endinterface

// File: rtl/axi_lsu_router.sv
// axi_lsu_router: routes the nox LSU AXI port to slave 0 (data RAM) or
// slave 1 (IROM mirror) by address. Per-direction outstanding counters pin
// responses to a single slave so R and B never interleave between slaves.
// Optional feature macro: AXI_LSU_ROUTER_DECERR_EN adds an internal DECERR
// responder for unmapped addresses; otherwise unmapped addresses go to slave 0.

module axi_lsu_router
  import axi_lsu_router_pkg::*;
#(
  parameter logic [31:0] S0_BASE  = 32'h1000_0000,
  parameter logic [31:0] S0_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE  = 32'h8000_0000,
  parameter logic [31:0] S1_MASK  = 32'hFFFF_0000,
  parameter int unsigned MAX_OUTS = 4
) (
  input logic             clk,
  input logic             arst,
  axi_lsu_router_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);
`ifdef AXI_LSU_ROUTER_DECERR_EN
  localparam int unsigned TGT_W = 2;
`else
  localparam int unsigned TGT_W = 1;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTS);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [TGT_W-1:0] TGT_S0   = TGT_W'(0);
  localparam logic [TGT_W-1:0] TGT_S1   = TGT_W'(1);
`ifdef AXI_LSU_ROUTER_DECERR_EN
  localparam logic [TGT_W-1:0] TGT_ERR  = TGT_W'(2);
`endif

  typedef enum logic {WR_IDLE, WR_DATA} wr_state_e;

  // Address decode; slave 1 wins an overlap with slave 0.
  function automatic logic [TGT_W-1:0] decode(input logic [31:0] addr);
    if ((addr & S1_MASK) == S1_BASE) begin
      return TGT_S1;
    end else if ((addr & S0_MASK) == S0_BASE) begin
      return TGT_S0;
    end
`ifdef AXI_LSU_ROUTER_DECERR_EN
    return TGT_ERR;
`else
    return TGT_S0;
`endif
  endfunction

  wr_state_e         wr_state_q, wr_state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [TGT_W-1:0]  rd_tgt_q, rd_tgt_d;
  logic [TGT_W-1:0]  wr_tgt_q, wr_tgt_d;
  logic [TGT_W-1:0]  w_tgt_q, w_tgt_d;

  s_axi_mosi_t       mosi_c;
  s_axi_miso_t       miso_c;
  s_axi_mosi_t [1:0] slv_mosi_c;
  s_axi_miso_t [1:0] slv_miso_c;
  logic [TGT_W-1:0]  ar_tgt_c, aw_tgt_c, w_route_c;
  logic              ar_allow_c, aw_allow_c, w_en_c;
  logic              ar_hs_c, aw_hs_c, w_hs_c, w_last_hs_c;
  logic              r_hs_c, r_last_hs_c, b_hs_c;

`ifdef AXI_LSU_ROUTER_DECERR_EN
  logic                 err_r_act_q;
  logic [AXI_LEN_W-1:0] err_r_left_q;
  logic [AXI_ID_W-1:0]  err_r_id_q;
  logic [AXI_ID_W-1:0]  err_b_id_q;
  logic                 err_b_q;
`endif

  assign mosi_c             = bus.mst_axi_mosi_i;
  assign slv_miso_c         = bus.slv_axi_miso_i;
  assign bus.mst_axi_miso_o = miso_c;
  assign bus.slv_axi_mosi_o = slv_mosi_c;

  // Routing of all five channels plus next-state for counters, targets and FSM.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      slv_mosi_c[i]         = mosi_c;
      slv_mosi_c[i].arvalid = 1'b0;
      slv_mosi_c[i].awvalid = 1'b0;
      slv_mosi_c[i].wvalid  = 1'b0;
      slv_mosi_c[i].rready  = 1'b0;
      slv_mosi_c[i].bready  = 1'b0;
    end
    miso_c    = '0;
    ar_tgt_c  = decode(mosi_c.araddr);
    aw_tgt_c  = decode(mosi_c.awaddr);
    w_route_c = w_tgt_q;
    w_en_c    = 1'b0;

    // AR: only to the slave already owning outstanding reads, within budget.
    ar_allow_c = (rd_cnt_q < CNT_MAX) && ((rd_cnt_q == CNT_ZERO) || (ar_tgt_c == rd_tgt_q));
`ifdef AXI_LSU_ROUTER_DECERR_EN
    if ((ar_tgt_c == TGT_ERR) && (rd_cnt_q != CNT_ZERO)) ar_allow_c = 1'b0;
`endif
    if (ar_allow_c) begin
`ifdef AXI_LSU_ROUTER_DECERR_EN
      if (ar_tgt_c == TGT_ERR) begin
        miso_c.arready = 1'b1;
      end else
`endif
      begin
        slv_mosi_c[ar_tgt_c[0]].arvalid = mosi_c.arvalid;
        miso_c.arready                  = slv_miso_c[ar_tgt_c[0]].arready;
      end
    end
    ar_hs_c = mosi_c.arvalid & miso_c.arready;

    // R: sourced from the owner of the outstanding reads.
    if (rd_cnt_q != CNT_ZERO) begin
`ifdef AXI_LSU_ROUTER_DECERR_EN
      if (rd_tgt_q == TGT_ERR) begin
        miso_c.rvalid = err_r_act_q;
        miso_c.rid    = err_r_id_q;
        miso_c.rresp  = 2'b11;
        miso_c.rlast  = (err_r_left_q == AXI_LEN_W'(0));
      end else
`endif
      begin
        miso_c.rvalid                  = slv_miso_c[rd_tgt_q[0]].rvalid;
        miso_c.rid                     = slv_miso_c[rd_tgt_q[0]].rid;
        miso_c.rdata                   = slv_miso_c[rd_tgt_q[0]].rdata;
        miso_c.rresp                   = slv_miso_c[rd_tgt_q[0]].rresp;
        miso_c.rlast                   = slv_miso_c[rd_tgt_q[0]].rlast;
        slv_mosi_c[rd_tgt_q[0]].rready = mosi_c.rready;
      end
    end
    r_hs_c      = miso_c.rvalid & mosi_c.rready;
    r_last_hs_c = r_hs_c & miso_c.rlast;

    // AW: same allow rule as AR, and only between bursts.
    aw_allow_c = (wr_state_q == WR_IDLE) && (wr_cnt_q < CNT_MAX) &&
                 ((wr_cnt_q == CNT_ZERO) || (aw_tgt_c == wr_tgt_q));
`ifdef AXI_LSU_ROUTER_DECERR_EN
    if ((aw_tgt_c == TGT_ERR) && (wr_cnt_q != CNT_ZERO)) aw_allow_c = 1'b0;
`endif
    if (aw_allow_c) begin
`ifdef AXI_LSU_ROUTER_DECERR_EN
      if (aw_tgt_c == TGT_ERR) begin
        miso_c.awready = 1'b1;
      end else
`endif
      begin
        slv_mosi_c[aw_tgt_c[0]].awvalid = mosi_c.awvalid;
        miso_c.awready                  = slv_miso_c[aw_tgt_c[0]].awready;
      end
    end
    aw_hs_c = mosi_c.awvalid & miso_c.awready;

    // W: open during a burst, or in the AW cycle using the new target.
    if (wr_state_q == WR_DATA) begin
      w_en_c = 1'b1;
    end else if (aw_hs_c) begin
      w_en_c    = 1'b1;
      w_route_c = aw_tgt_c;
    end
    if (w_en_c) begin
`ifdef AXI_LSU_ROUTER_DECERR_EN
      if (w_route_c == TGT_ERR) begin
        miso_c.wready = 1'b1;
      end else
`endif
      begin
        slv_mosi_c[w_route_c[0]].wvalid = mosi_c.wvalid;
        miso_c.wready                   = slv_miso_c[w_route_c[0]].wready;
      end
    end
    w_hs_c      = mosi_c.wvalid & miso_c.wready;
    w_last_hs_c = w_hs_c & mosi_c.wlast;

    // B: sourced from the owner of the outstanding writes.
    if (wr_cnt_q != CNT_ZERO) begin
`ifdef AXI_LSU_ROUTER_DECERR_EN
      if (wr_tgt_q == TGT_ERR) begin
        miso_c.bvalid = err_b_q;
        miso_c.bid    = err_b_id_q;
        miso_c.bresp  = 2'b11;
      end else
`endif
      begin
        miso_c.bvalid                  = slv_miso_c[wr_tgt_q[0]].bvalid;
        miso_c.bid                     = slv_miso_c[wr_tgt_q[0]].bid;
        miso_c.bresp                   = slv_miso_c[wr_tgt_q[0]].bresp;
        slv_mosi_c[wr_tgt_q[0]].bready = mosi_c.bready;
      end
    end
    b_hs_c = miso_c.bvalid & mosi_c.bready;

    rd_cnt_d = rd_cnt_q + CNT_W'(ar_hs_c) - CNT_W'(r_last_hs_c);
    wr_cnt_d = wr_cnt_q + CNT_W'(aw_hs_c) - CNT_W'(b_hs_c);
    rd_tgt_d = ar_hs_c ? ar_tgt_c : rd_tgt_q;
    wr_tgt_d = aw_hs_c ? aw_tgt_c : wr_tgt_q;
    w_tgt_d  = aw_hs_c ? aw_tgt_c : w_tgt_q;

    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE: if (aw_hs_c && !w_last_hs_c) wr_state_d = WR_DATA;
      WR_DATA: if (w_last_hs_c) wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Counters, owning targets and write FSM.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_state_q <= WR_IDLE;
      rd_cnt_q   <= CNT_ZERO;
      wr_cnt_q   <= CNT_ZERO;
      rd_tgt_q   <= TGT_S0;
      wr_tgt_q   <= TGT_S0;
      w_tgt_q    <= TGT_S0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_tgt_q   <= rd_tgt_d;
      wr_tgt_q   <= wr_tgt_d;
      w_tgt_q    <= w_tgt_d;
    end
  end

`ifdef AXI_LSU_ROUTER_DECERR_EN
  // Error responder: arlen+1 DECERR beats per AR, one DECERR B per write burst.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_r_act_q  <= 1'b0;
      err_r_left_q <= '0;
      err_r_id_q   <= '0;
      err_b_id_q   <= '0;
      err_b_q      <= 1'b0;
    end else begin
      if (ar_hs_c && (ar_tgt_c == TGT_ERR)) begin
        err_r_act_q  <= 1'b1;
        err_r_left_q <= mosi_c.arlen;
        err_r_id_q   <= mosi_c.arid;
      end else if (r_hs_c && (rd_tgt_q == TGT_ERR)) begin
        if (err_r_left_q == AXI_LEN_W'(0)) err_r_act_q <= 1'b0;
        else err_r_left_q <= err_r_left_q - AXI_LEN_W'(1);
      end
      if (aw_hs_c && (aw_tgt_c == TGT_ERR)) err_b_id_q <= mosi_c.awid;
      if (w_last_hs_c && (w_route_c == TGT_ERR)) begin
        err_b_q <= 1'b1;
      end else if (b_hs_c && (wr_tgt_q == TGT_ERR)) begin
        err_b_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_lsu_router.sv
// Directed bench for axi_lsu_router: decode table plus hand-written
// multi-cycle sequences (pipelining, target switch, write bursts, DECERR).

module tb_axi_lsu_router;
  import axi_lsu_router_pkg::*;

`ifdef AXI_LSU_ROUTER_DECERR_EN
  localparam bit DECERR = 1'b1;
`else
  localparam bit DECERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst;

  axi_lsu_router_if bus ();

  axi_lsu_router dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic        s0_rdy;
    logic        s1_rdy;
    logic        exp_v0;
    logic        exp_v1;
    logic        exp_rdy;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.mst_axi_mosi_i = '0;
    bus.slv_axi_miso_i = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fill one decode vector; unmapped expectations depend on the build.
  function automatic vec_t mk(input logic wr, input logic [31:0] addr,
                              input logic r0, input logic r1, input int tgt);
    vec_t v;
    v.wr = wr; v.addr = addr; v.s0_rdy = r0; v.s1_rdy = r1;
    if (tgt == 1) begin
      v.exp_v0 = 1'b0; v.exp_v1 = 1'b1; v.exp_rdy = r1;
    end else if (tgt == 0 || !DECERR) begin
      v.exp_v0 = 1'b1; v.exp_v1 = 1'b0; v.exp_rdy = r0;
    end else begin
      v.exp_v0 = 1'b0; v.exp_v1 = 1'b0; v.exp_rdy = 1'b1;
    end
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit leak;

    // tgt: 0 = S0, 1 = S1, 2 = unmapped
    vecs[0] = mk(1'b0, 32'h8000_0010, 1'b0, 1'b1, 1);
    vecs[1] = mk(1'b0, 32'h1000_0004, 1'b1, 1'b0, 0);
    vecs[2] = mk(1'b0, 32'h1000_FFFC, 1'b0, 1'b1, 0);
    vecs[3] = mk(1'b0, 32'h1001_0000, 1'b1, 1'b1, 2);
    vecs[4] = mk(1'b0, 32'h8000_FFFF, 1'b1, 1'b0, 1);
    vecs[5] = mk(1'b1, 32'h8001_0000, 1'b0, 1'b1, 2);
    vecs[6] = mk(1'b1, 32'h8000_1234, 1'b0, 1'b1, 1);
    vecs[7] = mk(1'b1, 32'h1000_0000, 1'b1, 1'b1, 0);
    vecs[8] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b0, 2);

    // Reset: slave responses present but nothing may reach the master.
    idle();
    arst = 1'b1;
    bus.slv_axi_miso_i[0].rvalid = 1'b1;
    bus.slv_axi_miso_i[0].bvalid = 1'b1;
    bus.slv_axi_miso_i[1].rvalid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_slv_arvalid", {bus.slv_axi_mosi_o[1].arvalid, bus.slv_axi_mosi_o[0].arvalid}, 2'b00);
    chk("rst_slv_awvalid", {bus.slv_axi_mosi_o[1].awvalid, bus.slv_axi_mosi_o[0].awvalid}, 2'b00);
    chk("rst_slv_wvalid", {bus.slv_axi_mosi_o[1].wvalid, bus.slv_axi_mosi_o[0].wvalid}, 2'b00);
    chk("rst_mst_readies", {bus.mst_axi_miso_o.arready, bus.mst_axi_miso_o.awready,
                            bus.mst_axi_miso_o.wready}, 3'b000);
    chk("rst_mst_rvalid", bus.mst_axi_miso_o.rvalid, 1'b0);
    chk("rst_mst_bvalid", bus.mst_axi_miso_o.bvalid, 1'b0);
    idle();
    arst = 1'b0;
    step();

    // Decode table: present the request, sample, withdraw before the edge.
    for (int i = 0; i < NV; i++) begin
      idle();
      if (!vecs[i].wr) begin
        bus.slv_axi_miso_i[0].arready = vecs[i].s0_rdy;
        bus.slv_axi_miso_i[1].arready = vecs[i].s1_rdy;
        bus.mst_axi_mosi_i.araddr     = vecs[i].addr;
        bus.mst_axi_mosi_i.arvalid    = 1'b1;
        #1;
        chk($sformatf("vec%0d_arvalid0", i), bus.slv_axi_mosi_o[0].arvalid, vecs[i].exp_v0);
        chk($sformatf("vec%0d_arvalid1", i), bus.slv_axi_mosi_o[1].arvalid, vecs[i].exp_v1);
        chk($sformatf("vec%0d_arready", i), bus.mst_axi_miso_o.arready, vecs[i].exp_rdy);
      end else begin
        bus.slv_axi_miso_i[0].awready = vecs[i].s0_rdy;
        bus.slv_axi_miso_i[1].awready = vecs[i].s1_rdy;
        bus.mst_axi_mosi_i.awaddr     = vecs[i].addr;
        bus.mst_axi_mosi_i.awvalid    = 1'b1;
        #1;
        chk($sformatf("vec%0d_awvalid0", i), bus.slv_axi_mosi_o[0].awvalid, vecs[i].exp_v0);
        chk($sformatf("vec%0d_awvalid1", i), bus.slv_axi_mosi_o[1].awvalid, vecs[i].exp_v1);
        chk($sformatf("vec%0d_awready", i), bus.mst_axi_miso_o.awready, vecs[i].exp_rdy);
      end
      idle();
      step();
    end

    // Same-target pipelining: four ARs back to back, fifth stalls.
    idle();
    bus.slv_axi_miso_i[0].arready = 1'b1;
    bus.mst_axi_mosi_i.arvalid    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mst_axi_mosi_i.araddr = 32'h1000_0000 + 32'(4 * i);
      bus.mst_axi_mosi_i.arid   = 4'(i);
      #1;
      chk($sformatf("pipe_arready%0d", i), bus.mst_axi_miso_o.arready, 1'b1);
      step();
    end
    bus.mst_axi_mosi_i.araddr = 32'h1000_0010;
    bus.mst_axi_mosi_i.arid   = 4'd4;
    #1;
    chk("pipe_full_arready", bus.mst_axi_miso_o.arready, 1'b0);
    chk("pipe_full_arvalid0", bus.slv_axi_mosi_o[0].arvalid, 1'b0);
    step();
    bus.mst_axi_mosi_i.rready         = 1'b1;
    bus.slv_axi_miso_i[0].rvalid      = 1'b1;
    bus.slv_axi_miso_i[0].rlast       = 1'b1;
    bus.slv_axi_miso_i[0].rdata       = 32'hD000_0000;
    #1;
    chk("pipe_stall_with_r", bus.mst_axi_miso_o.arready, 1'b0);
    chk("pipe_r0_data", bus.mst_axi_miso_o.rdata, 32'hD000_0000);
    chk("pipe_r0_rready0", bus.slv_axi_mosi_o[0].rready, 1'b1);
    step();
    bus.slv_axi_miso_i[0].rvalid = 1'b0;
    #1;
    chk("pipe_fifth_accept", bus.mst_axi_miso_o.arready, 1'b1);
    step();
    bus.mst_axi_mosi_i.arvalid   = 1'b0;
    bus.slv_axi_miso_i[0].rvalid = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      bus.slv_axi_miso_i[0].rdata = 32'hD000_0000 + 32'(j);
      #1;
      chk($sformatf("pipe_r%0d_data", j), bus.mst_axi_miso_o.rdata, 32'hD000_0000 + 32'(j));
      step();
    end
    #1;
    chk("pipe_drained_rvalid", bus.mst_axi_miso_o.rvalid, 1'b0);
    chk("pipe_drained_rready0", bus.slv_axi_mosi_o[0].rready, 1'b0);

    // Simultaneous AR and last-R at two outstanding.
    idle();
    bus.slv_axi_miso_i[0].arready = 1'b1;
    bus.mst_axi_mosi_i.araddr     = 32'h1000_0020;
    bus.mst_axi_mosi_i.arvalid    = 1'b1;
    step();
    step();
    chk("sim_cnt_before", 64'(dut.rd_cnt_q), 2);
    bus.mst_axi_mosi_i.rready    = 1'b1;
    bus.slv_axi_miso_i[0].rvalid = 1'b1;
    bus.slv_axi_miso_i[0].rlast  = 1'b1;
    step();
    chk("sim_cnt_after", 64'(dut.rd_cnt_q), 2);
    bus.mst_axi_mosi_i.arvalid = 1'b0;
    step();
    step();
    chk("sim_cnt_drained", 64'(dut.rd_cnt_q), 0);

    // Target switch: S1 AR held until S0's delayed R completes.
    idle();
    bus.slv_axi_miso_i[0].arready = 1'b1;
    bus.slv_axi_miso_i[1].arready = 1'b1;
    bus.mst_axi_mosi_i.araddr     = 32'h1000_0100;
    bus.mst_axi_mosi_i.arvalid    = 1'b1;
    step();
    bus.mst_axi_mosi_i.araddr = 32'h8000_0000;
    bus.mst_axi_mosi_i.rready = 1'b1;
    leak = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.slv_axi_mosi_o[1].arvalid || bus.mst_axi_miso_o.arready || bus.mst_axi_miso_o.rvalid)
        leak = 1'b1;
      step();
    end
    chk("sw_held_10cyc", leak, 1'b0);
    bus.slv_axi_miso_i[0].rvalid = 1'b1;
    bus.slv_axi_miso_i[0].rlast  = 1'b1;
    bus.slv_axi_miso_i[0].rdata  = 32'h5A5A_5A5A;
    #1;
    chk("sw_s0_rdata", bus.mst_axi_miso_o.rdata, 32'h5A5A_5A5A);
    chk("sw_s1_arvalid_last_r", bus.slv_axi_mosi_o[1].arvalid, 1'b0);
    step();
    bus.slv_axi_miso_i[0].rdata = 32'h0000_0BAD;
    #1;
    chk("sw_s1_arvalid_fwd", bus.slv_axi_mosi_o[1].arvalid, 1'b1);
    chk("sw_arready_fwd", bus.mst_axi_miso_o.arready, 1'b1);
    chk("sw_no_stray_r", bus.mst_axi_miso_o.rvalid, 1'b0);
    step();
    bus.mst_axi_mosi_i.arvalid   = 1'b0;
    bus.slv_axi_miso_i[1].rvalid = 1'b1;
    bus.slv_axi_miso_i[1].rlast  = 1'b1;
    bus.slv_axi_miso_i[1].rdata  = 32'h1111_1111;
    #1;
    chk("sw_s1_rdata", bus.mst_axi_miso_o.rdata, 32'h1111_1111);
    chk("sw_s0_rready_off", bus.slv_axi_mosi_o[0].rready, 1'b0);
    step();

    // Write burst: AW len=3 to S0, four beats, second AW blocked meanwhile.
    idle();
    bus.slv_axi_miso_i[0].awready = 1'b1;
    bus.slv_axi_miso_i[0].wready  = 1'b1;
    bus.slv_axi_miso_i[1].awready = 1'b1;
    bus.mst_axi_mosi_i.awaddr     = 32'h1000_0040;
    bus.mst_axi_mosi_i.awlen      = 8'd3;
    bus.mst_axi_mosi_i.awid       = 4'd5;
    bus.mst_axi_mosi_i.awvalid    = 1'b1;
    #1;
    chk("wb_aw_fwd", {bus.slv_axi_mosi_o[1].awvalid, bus.slv_axi_mosi_o[0].awvalid}, 2'b01);
    step();
    bus.mst_axi_mosi_i.awaddr = 32'h8000_0080;
    for (int b = 0; b < 4; b++) begin
      bus.mst_axi_mosi_i.wdata  = 32'hC0 + 32'(b);
      bus.mst_axi_mosi_i.wvalid = 1'b1;
      bus.mst_axi_mosi_i.wlast  = (b == 3);
      #1;
      chk($sformatf("wb_w%0d_route", b), {bus.slv_axi_mosi_o[1].wvalid, bus.slv_axi_mosi_o[0].wvalid}, 2'b01);
      chk($sformatf("wb_w%0d_aw_blocked", b), {bus.mst_axi_miso_o.awready,
          bus.slv_axi_mosi_o[1].awvalid, bus.slv_axi_mosi_o[0].awvalid}, 3'b000);
      chk($sformatf("wb_w%0d_wready", b), bus.mst_axi_miso_o.wready, 1'b1);
      step();
    end
    bus.mst_axi_mosi_i.awvalid = 1'b0;
    bus.mst_axi_mosi_i.wlast   = 1'b0;
    #1;
    chk("wb_idle_wready", bus.mst_axi_miso_o.wready, 1'b0);
    chk("wb_idle_wvalid0", bus.slv_axi_mosi_o[0].wvalid, 1'b0);
    bus.mst_axi_mosi_i.wvalid    = 1'b0;
    bus.mst_axi_mosi_i.bready    = 1'b1;
    bus.slv_axi_miso_i[0].bvalid = 1'b1;
    bus.slv_axi_miso_i[0].bid    = 4'd5;
    #1;
    chk("wb_b_fwd", {bus.mst_axi_miso_o.bvalid, 4'(bus.mst_axi_miso_o.bid)}, {1'b1, 4'd5});
    step();
    chk("wb_wr_cnt_zero", 64'(dut.wr_cnt_q), 0);
    chk("wb_no_extra_b", bus.mst_axi_miso_o.bvalid, 1'b0);

    // AW and single W beat to S1 in the same cycle.
    idle();
    bus.slv_axi_miso_i[1].awready = 1'b1;
    bus.slv_axi_miso_i[1].wready  = 1'b1;
    bus.mst_axi_mosi_i.awaddr     = 32'h8000_0020;
    bus.mst_axi_mosi_i.awvalid    = 1'b1;
    bus.mst_axi_mosi_i.wvalid     = 1'b1;
    bus.mst_axi_mosi_i.wlast      = 1'b1;
    #1;
    chk("aww_route_s1", {bus.slv_axi_mosi_o[1].wvalid, bus.slv_axi_mosi_o[0].wvalid}, 2'b10);
    chk("aww_wready", bus.mst_axi_miso_o.wready, 1'b1);
    step();
    bus.mst_axi_mosi_i.awvalid = 1'b0;
    #1;
    chk("aww_back_idle", bus.mst_axi_miso_o.wready, 1'b0);
    bus.mst_axi_mosi_i.wvalid    = 1'b0;
    bus.mst_axi_mosi_i.bready    = 1'b1;
    bus.slv_axi_miso_i[1].bvalid = 1'b1;
    #1;
    chk("aww_b_s1", bus.mst_axi_miso_o.bvalid, 1'b1);
    step();
    idle();

    // Unmapped AR with len=1.
    bus.slv_axi_miso_i[0].arready = 1'b1;
    bus.slv_axi_miso_i[1].arready = 1'b1;
    bus.mst_axi_mosi_i.araddr     = 32'h4000_0000;
    bus.mst_axi_mosi_i.arlen      = 8'd1;
    bus.mst_axi_mosi_i.arid       = 4'd3;
    bus.mst_axi_mosi_i.arvalid    = 1'b1;
    #1;
    if (DECERR) begin
      chk("de_arready", bus.mst_axi_miso_o.arready, 1'b1);
      chk("de_not_fwd", {bus.slv_axi_mosi_o[1].arvalid, bus.slv_axi_mosi_o[0].arvalid}, 2'b00);
      step();
      bus.mst_axi_mosi_i.arvalid = 1'b0;
      bus.mst_axi_mosi_i.rready  = 1'b1;
      #1;
      chk("de_beat1", {bus.mst_axi_miso_o.rvalid, bus.mst_axi_miso_o.rresp,
                       bus.mst_axi_miso_o.rlast, 4'(bus.mst_axi_miso_o.rid)}, {1'b1, 2'b11, 1'b0, 4'd3});
      chk("de_beat1_data", bus.mst_axi_miso_o.rdata, 32'h0);
      step();
      chk("de_beat2", {bus.mst_axi_miso_o.rvalid, bus.mst_axi_miso_o.rresp,
                       bus.mst_axi_miso_o.rlast}, {1'b1, 2'b11, 1'b1});
      step();
      chk("de_done", bus.mst_axi_miso_o.rvalid, 1'b0);
    end else begin
      chk("unmapped_to_s0", {bus.slv_axi_mosi_o[1].arvalid, bus.slv_axi_mosi_o[0].arvalid}, 2'b01);
      chk("unmapped_arready", bus.mst_axi_miso_o.arready, 1'b1);
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
